// File: rtl/mul_pkg.sv
// Shared multiply definitions: ALUControl encodings and iterative unit state encoding.
package mul_pkg;

  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_UMULL = 4'b1000;
  localparam logic [3:0] OP_SMULL = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mul_state_e;

  // True for the three encodings the multiplier accepts.
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL);
  endfunction

endpackage

// File: rtl/mul_iter_unit_if.sv
// Start/busy/done handshake plus operand and result buses of the iterative multiplier.
interface mul_iter_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;

  modport master (
    output Start, ALUControl, SrcA, SrcB,
    input  Busy, Done, ResultLo, ResultHi
  );

  modport slave (
    input  Start, ALUControl, SrcA, SrcB,
    output Busy, Done, ResultLo, ResultHi
  );
endinterface

// File: rtl/mul_iter_unit.sv
// Radix-2 shift-add multiplier: MUL / UMULL / SMULL with fixed WIDTH+2 cycle latency.
module mul_iter_unit
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           reset,
  mul_iter_unit_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;

  mul_state_e       state_q, state_d;
  logic             mul_q, mul_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic             accept_c;
  logic             smull_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    prod_c;

  // Operand conditioning: SMULL runs on magnitudes, sign is re-applied in SIGN.
  assign accept_c = bus.Start && is_mul_op(bus.ALUControl);
  assign smull_c  = (bus.ALUControl == OP_SMULL);
  assign abs_a_c  = (smull_c && bus.SrcA[WIDTH-1]) ? (~bus.SrcA + WIDTH'(1)) : bus.SrcA;
  assign abs_b_c  = (smull_c && bus.SrcB[WIDTH-1]) ? (~bus.SrcB + WIDTH'(1)) : bus.SrcB;

  // Partial-product add into the upper half, carry kept as the extra bit.
  assign sum_c  = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (mplr_q[0] ? mcand_q : WIDTH'(0))};
  assign prod_c = neg_q ? (~acc_q + PW'(1)) : acc_q;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    mul_d   = mul_q;
    neg_d   = neg_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;

    case (state_q)
      // DONE doubles as an accept slot so back-to-back ops issue every WIDTH+2 edges.
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept_c) begin
          mul_d   = (bus.ALUControl == OP_MUL);
          neg_d   = smull_c && (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
          mcand_d = abs_a_c;
          mplr_d  = abs_b_c;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = {sum_c, acc_q[WIDTH-1:1]};
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        lo_d    = prod_c[WIDTH-1:0];
        hi_d    = mul_q ? '0 : prod_c[PW-1:WIDTH];
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == SIGN);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      mul_q   <= mul_d;
      neg_q   <= neg_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.ResultLo = lo_q;
  assign bus.ResultHi = hi_q;

endmodule
